// File: rtl/part_6_serial_addsub.sv
// Multi-cycle add/sub: processes CHUNK bits per clock through a registered carry,
// with a start/busy/done handshake plus carry-out and signed-overflow flags.
module part_6_serial_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OFFW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              busy_d, done_d, co_d, ov_d;
  logic [WIDTH-1:0]  sum_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [OFFW-1:0]   off;
  logic [CHUNK:0]    chunk_full;

  // Bit offset of the chunk handled this cycle, and its sum with carry-in
  assign off        = OFFW'(idx_q) * OFFW'(CHUNK);
  assign chunk_full = {1'b0, a_q[off +: CHUNK]} + {1'b0, b_q[off +: CHUNK]}
                    + (CHUNK + 1)'(carry_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      sum       <= sum_d;
      carry_out <= co_d;
      overflow  <= ov_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    busy_d  = busy;
    done_d  = 1'b0;
    sum_d   = sum;
    co_d    = carry_out;
    ov_d    = overflow;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[off +: CHUNK] = chunk_full[CHUNK-1:0];
        carry_d             = chunk_full[CHUNK];
        idx_d               = idx_q + IDXW'(1);
        if (idx_q == IDXW'(N - 1)) begin
          // Carry into MSB recovered from the MSB sum bit and its operands
          sum_d   = acc_d;
          co_d    = chunk_full[CHUNK];
          ov_d    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_full[CHUNK-1] ^ chunk_full[CHUNK];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_part_6_serial_addsub.sv
// Self-checking bench for part_6_serial_addsub: directed and random operations
// compared every cycle against a cycle-count arithmetic model.
module tb_part_6_serial_addsub;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             reset, start, sub;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, carry_out, overflow;
  logic [WIDTH-1:0] sum;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic             m_busy = 1'b0, m_done = 1'b0, m_co = 1'b0, m_ov = 1'b0;
  logic [WIDTH-1:0] m_sum = '0;
  int               m_cnt = 0;
  logic [WIDTH+1:0] pend = '0;

  part_6_serial_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Returns {overflow, carry_out, sum} from plain wide arithmetic
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic s);
    logic [WIDTH:0] r;
    logic           ov;
    if (s) begin
      r  = {1'b0, x} + {1'b0, ~y} + (WIDTH + 1)'(1);
      ov = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    end else begin
      r  = {1'b0, x} + {1'b0, y};
      ov = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    end
    return {ov, r};
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare all outputs
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_co = 1'b0; m_ov = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_ov, m_co, m_sum} = pend;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_cnt  = N;
        pend   = ref_op(a, b, sub);
      end
    end
    #1;
    chk("busy",      WIDTH'(busy),      WIDTH'(m_busy));
    chk("done",      WIDTH'(done),      WIDTH'(m_done));
    chk("sum",       sum,               m_sum);
    chk("carry_out", WIDTH'(carry_out), WIDTH'(m_co));
    chk("overflow",  WIDTH'(overflow),  WIDTH'(m_ov));
  endtask

  // Issue one operation, scramble inputs during RUN, and check latency and result
  task automatic op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                    input logic s, input logic [WIDTH-1:0] e_sum, input logic e_co,
                    input logic e_ov);
    int n;
    start = 1'b1; a = x; b = y; sub = s;
    step();
    n = 0;
    while (!done && n < 10) begin
      start = 1'($urandom_range(0, 1));
      a     = $urandom;
      b     = $urandom;
      sub   = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, WIDTH'(n), WIDTH'(N));
    chk({tag, "_sum"}, sum, e_sum);
    chk({tag, "_co"},  WIDTH'(carry_out), WIDTH'(e_co));
    chk({tag, "_ov"},  WIDTH'(overflow),  WIDTH'(e_ov));
  endtask

  initial begin
    int dones;
    logic [WIDTH-1:0] rx, ry;
    logic             rs;
    logic [WIDTH+1:0] r;

    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("reset_sum",  sum,          '0);
    chk("reset_busy", WIDTH'(busy), '0);
    reset = 1'b0;
    step();

    op("t1_add",     32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    op("t2_sub_eq",  32'h0000_0002, 32'h0000_0002, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    op("t2_sub_neg", 32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op("t3_add_x",   32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    op("t3_sub_x",   32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0);
    op("t4_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    op("t4_povf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    op("t4_novf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Start held high with changing operands: accepts land at edges 0 and 5
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      step();
      if (done) dones++;
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dones++;
    end
    chk("hs_done_count", WIDTH'(dones), WIDTH'(2));

    // Reset two cycles into RUN aborts the operation with no done pulse
    start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("abort_busy", WIDTH'(busy), '0);
    chk("abort_done", WIDTH'(done), '0);
    chk("abort_sum",  sum,          '0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dones++;
    end
    chk("abort_no_done", WIDTH'(dones), '0);
    op("post_abort", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

    // Random operations, back-to-back where op issues start in the done cycle
    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      ry = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) ry = rx;
      if (i % 8 == 1) rx = 32'h8000_0000;
      r = ref_op(rx, ry, rs);
      op("rand", rx, ry, rs, r[WIDTH-1:0], r[WIDTH], r[WIDTH+1]);
    end

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
